bank_queue_ctrl: RTL and testbench

Parametrised queue controller for the bank queue system. It debounces the two active-low photocells, keeps a saturating occupancy count with empty/full flags, and computes the estimated waiting time with a sequential restoring divider. It drives BCD digit pairs straight into the existing seven-segment decoders, replacing the fixed-size queue and display pair.

---
 rtl/bank_queue_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_bank_queue_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_queue_ctrl.sv
// Bank queue controller: debounced photocells, occupancy count,
// sequential wait-time divider and registered BCD digit outputs.
module bank_queue_ctrl #(
  parameter int MAX_PEOPLE      = 15,
  parameter int SERVICE_TIME    = 3,
  parameter int TELLER_W        = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  localparam int PC_W   = $clog2(MAX_PEOPLE + 1),
  localparam int WAIT_W = $clog2(SERVICE_TIME * MAX_PEOPLE + 1),
  localparam int NUM_W  =
    $clog2(SERVICE_TIME * (MAX_PEOPLE + 2**TELLER_W - 2) + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                phcOne,
  input  logic                phcTwo,
  input  logic [TELLER_W-1:0] Tcount,
  output logic [PC_W-1:0]     Pcount,
  output logic [WAIT_W-1:0]   Pwait,
  output logic [3:0]          pTens,
  output logic [3:0]          pUnits,
  output logic [3:0]          wTens,
  output logic [3:0]          wUnits,
  output logic [1:0]          flags,
  output logic                waitValid,
  output logic                noTeller
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BCNT_W = $clog2(NUM_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  logic [1:0]       phc;
  logic [1:0]       s1_q, s2_q;
  logic [1:0]       stb_q, stbPrev_q;
  logic [CNT_W-1:0] cnt_q [2];
  logic [1:0]       evt;

  logic [PC_W-1:0]     pc_q, pcPrev_q;
  logic [TELLER_W-1:0] tcPrev_q;
  logic                noTeller_q;

  state_e              state_q, state_d;
  logic [NUM_W-1:0]    num_q, num_d;
  logic [TELLER_W-1:0] div_q, div_d;
  logic [TELLER_W-1:0] rem_q, rem_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic                zero_q, zero_d;
  logic [WAIT_W-1:0]   pwait_q, pwait_d;
  logic                wvalid_q, wvalid_d;

  logic [7:0] pBcd_q, wBcd_q;

  logic                chg;
  logic [NUM_W-1:0]    num_calc;
  logic [TELLER_W:0]   trial;
  logic                ge;

  assign phc = {phcTwo, phcOne};
  assign evt = stbPrev_q & ~stb_q;

  // Synchroniser and debounce; stable level moves only after a full hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q      <= 2'b11;
      s2_q      <= 2'b11;
      stb_q     <= 2'b11;
      stbPrev_q <= 2'b11;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      s1_q      <= phc;
      s2_q      <= s1_q;
      stbPrev_q <= stb_q;
      for (int i = 0; i < 2; i++) begin
        if (s2_q[i] == stb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stb_q[i] <= s2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q <= '0;
    end else if (evt[0] && !evt[1] && pc_q != PC_W'(MAX_PEOPLE)) begin
      pc_q <= pc_q + 1'b1;
    end else if (evt[1] && !evt[0] && pc_q != '0) begin
      pc_q <= pc_q - 1'b1;
    end
  end

  assign chg = (pc_q != pcPrev_q) || (Tcount != tcPrev_q);
  assign num_calc = NUM_W'(SERVICE_TIME *
    (int'(pc_q) + int'(Tcount) - 1));
  assign trial = {rem_q, num_q[NUM_W-1]};
  assign ge = trial >= {1'b0, div_q};

  // Quotient bits shift into the numerator register as it empties.
  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    div_d    = div_q;
    rem_d    = rem_q;
    bcnt_d   = bcnt_q;
    zero_d   = zero_q;
    pwait_d  = pwait_q;
    wvalid_d = wvalid_q;
    unique case (state_q)
      S_IDLE: ;
      S_CALC: begin
        rem_d  = ge ? TELLER_W'(trial - {1'b0, div_q})
                    : trial[TELLER_W-1:0];
        num_d  = {num_q[NUM_W-2:0], ge};
        bcnt_d = bcnt_q + 1'b1;
        if (bcnt_q == BCNT_W'(NUM_W - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        pwait_d  = zero_q ? '0 : WAIT_W'(num_q);
        wvalid_d = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (chg) begin
      num_d    = num_calc;
      div_d    = Tcount;
      rem_d    = '0;
      bcnt_d   = '0;
      zero_d   = (pc_q == '0) || (Tcount == '0);
      wvalid_d = 1'b0;
      pwait_d  = pwait_q;
      state_d  = zero_d ? S_DONE : S_CALC;
    end
  end

  always_ff @(posedge clock) begin
    noTeller_q <= Tcount == '0;
    if (reset) begin
      state_q  <= S_IDLE;
      num_q    <= '0;
      div_q    <= '0;
      rem_q    <= '0;
      bcnt_q   <= '0;
      zero_q   <= 1'b0;
      pwait_q  <= '0;
      wvalid_q <= 1'b1;
      pcPrev_q <= '0;
      tcPrev_q <= Tcount;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      div_q    <= div_d;
      rem_q    <= rem_d;
      bcnt_q   <= bcnt_d;
      zero_q   <= zero_d;
      pwait_q  <= pwait_d;
      wvalid_q <= wvalid_d;
      pcPrev_q <= pc_q;
      tcPrev_q <= Tcount;
    end
  end

  function automatic logic [7:0] to_bcd(logic [6:0] v);
    logic [3:0] t;
    t = '0;
    for (int k = 1; k < 10; k++) begin
      if (v >= 7'(10 * k)) t = 4'(k);
    end
    return {t, 4'(v - 7'(10 * t))};
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      pBcd_q <= '0;
      wBcd_q <= '0;
    end else begin
      pBcd_q <= to_bcd(7'(pc_q));
      wBcd_q <= to_bcd(7'(pwait_q));
    end
  end

  assign Pcount    = pc_q;
  assign Pwait     = pwait_q;
  assign pTens     = pBcd_q[7:4];
  assign pUnits    = pBcd_q[3:0];
  assign wTens     = wBcd_q[7:4];
  assign wUnits    = wBcd_q[3:0];
  assign flags     = {pc_q == PC_W'(MAX_PEOPLE), pc_q == '0};
  assign waitValid = wvalid_q;
  assign noTeller  = noTeller_q;

endmodule

// File: tb/tb_bank_queue_ctrl.sv
// Scoreboard bench for bank_queue_ctrl: stimulus queues expected
// Pcount/Pwait events, a negedge monitor pops and compares them.
module tb_bank_queue_ctrl;

  logic       clk;
  logic       rst;
  logic       phcOne, phcTwo;
  logic [1:0] Tcount;
  logic [3:0] Pcount;
  logic [5:0] Pwait;
  logic [3:0] pTens, pUnits, wTens, wUnits;
  logic [1:0] flags;
  logic       waitValid, noTeller;

  bank_queue_ctrl dut (
    .clock     (clk),
    .reset     (rst),
    .phcOne    (phcOne),
    .phcTwo    (phcTwo),
    .Tcount    (Tcount),
    .Pcount    (Pcount),
    .Pwait     (Pwait),
    .pTens     (pTens),
    .pUnits    (pUnits),
    .wTens     (wTens),
    .wUnits    (wUnits),
    .flags     (flags),
    .waitValid (waitValid),
    .noTeller  (noTeller)
  );

  typedef struct {
    int v;
    int c;
  } exp_t;

  exp_t pcq[$];
  exp_t wq[$];
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  name, act, exp, cyc);
  endtask

  // Monitor: pops expectations whenever Pcount moves or waitValid rises.
  int   lastPc = 0;
  logic lastWv = 1'b1;
  bit   pendP = 0, pendW = 0;
  int   pExp = 0, wExp = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      lastPc = int'(Pcount);
      lastWv = waitValid;
      pendP = 0;
      pendW = 0;
    end else begin
      if (pendP) begin
        chk("pTens", pTens, pExp / 10);
        chk("pUnits", pUnits, pExp % 10);
        pendP = 0;
      end
      if (pendW) begin
        chk("wTens", wTens, wExp / 10);
        chk("wUnits", wUnits, wExp % 10);
        pendW = 0;
      end
      if (int'(Pcount) != lastPc) begin
        if (pcq.size() == 0) begin
          chk("pc_unexpected", Pcount, lastPc);
        end else begin
          e = pcq.pop_front();
          chk("pcount", Pcount, e.v);
          chk("pc_latency", cyc, e.c);
          chk("flags", flags, {e.v == 15, e.v == 0});
          pExp = e.v;
          pendP = 1;
        end
        lastPc = int'(Pcount);
      end
      if (waitValid && !lastWv) begin
        if (wq.size() == 0) begin
          chk("wait_unexpected", Pwait, -1);
        end else begin
          e = wq.pop_front();
          chk("pwait", Pwait, e.v);
          chk("wait_latency", cyc, e.c);
          wExp = e.v;
          pendW = 1;
        end
      end
      lastWv = waitValid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(int n);
    repeat (n) tick();
  endtask

  // One 10-cycle low pulse; pc < 0 / w < 0 mean no event expected.
  task automatic pulse(bit ent, bit ext, int pc, int w, int wlat);
    int n;
    n = cyc;
    if (pc >= 0) pcq.push_back('{pc, n + 7});
    if (w >= 0) wq.push_back('{w, n + 7 + wlat});
    if (ent) phcOne = 0;
    if (ext) phcTwo = 0;
    wait_cyc(10);
    phcOne = 1;
    phcTwo = 1;
    wait_cyc(10);
  endtask

  task automatic set_tellers(logic [1:0] t, int w, int wlat);
    int n;
    n = cyc;
    wq.push_back('{w, n + wlat});
    Tcount = t;
    wait_cyc(12);
  endtask

  task automatic do_reset(logic [1:0] t);
    rst = 1;
    Tcount = t;
    phcOne = 1;
    phcTwo = 1;
    wait_cyc(3);
    rst = 0;
    tick();
  endtask

  int n0;

  initial begin
    do_reset(2'd2);
    @(negedge clk);
    chk("rst_pcount", Pcount, 0);
    chk("rst_flags", flags, 1);
    chk("rst_pwait", Pwait, 0);
    chk("rst_valid", waitValid, 1);
    chk("rst_noteller", noTeller, 0);
    chk("rst_digits", {pTens, pUnits, wTens, wUnits}, 0);
    tick();
    wait_cyc(50);
    @(negedge clk);
    chk("idle_pcount", Pcount, 0);
    chk("idle_valid", waitValid, 1);
    chk("idle_pwait", Pwait, 0);
    tick();

    // Tcount=2: waits 3,4,6,7,9
    pulse(1, 0, 1, 3, 8);
    pulse(1, 0, 2, 4, 8);
    pulse(1, 0, 3, 6, 8);
    pulse(1, 0, 4, 7, 8);
    pulse(1, 0, 5, 9, 8);

    // Tcount=3: wait = Pcount + 2
    set_tellers(2'd3, 7, 8);
    for (int p = 6; p <= 15; p++) pulse(1, 0, p, p + 2, 8);
    pulse(1, 0, -1, -1, 0);
    pulse(1, 1, -1, -1, 0);
    @(negedge clk);
    chk("full_hold", Pcount, 15);
    chk("full_flags", flags, 2);
    tick();
    pulse(0, 1, 14, 16, 8);

    do_reset(2'd1);
    pulse(1, 0, 1, 3, 8);
    phcTwo = 0;
    wait_cyc(3);
    phcTwo = 1;
    wait_cyc(15);
    @(negedge clk);
    chk("glitch_pcount", Pcount, 1);
    tick();
    pulse(0, 1, 0, 0, 2);
    pulse(0, 1, -1, -1, 0);
    @(negedge clk);
    chk("empty_pcount", Pcount, 0);
    chk("empty_flags", flags, 1);
    chk("empty_pwait", Pwait, 0);
    tick();

    set_tellers(2'd2, 0, 2);
    pulse(1, 0, 1, 3, 8);
    pulse(1, 0, 2, 4, 8);
    pulse(1, 0, 3, 6, 8);
    pulse(1, 0, 4, 7, 8);

    // Tcount 2->3 three cycles into the 4->5 recompute
    n0 = cyc;
    pcq.push_back('{5, n0 + 7});
    wq.push_back('{7, n0 + 18});
    phcOne = 0;
    wait_cyc(10);
    Tcount = 2'd3;
    wait_cyc(5);
    @(negedge clk);
    chk("restart_valid", waitValid, 0);
    tick();
    phcOne = 1;
    wait_cyc(15);

    n0 = cyc;
    wq.push_back('{0, n0 + 2});
    Tcount = 2'd0;
    tick();
    @(negedge clk);
    chk("noteller", noTeller, 1);
    tick();
    wait_cyc(6);
    @(negedge clk);
    chk("noteller_pwait", Pwait, 0);
    chk("pc_queue_left", pcq.size(), 0);
    chk("wait_queue_left", wq.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
